// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: signal bundle between the pipelined control unit and the datapath/hazard unit
//   master : control unit (drives decode/execute/memory/writeback controls)
//   slave  : datapath/hazard side (drives InstrD, ALUFlags, FlushE)
//   BranchCnt/CondFailCnt exist only when PIPE_CTRL_PERF_EN is defined
interface pipe_ctrl_if #(parameter int PERF_W = 32);
   logic [19:0] InstrD;
   logic [3:0]  ALUFlags;
   logic        FlushE;
   logic [1:0]  RegSrcD;
   logic [1:0]  ImmSrcD;
   logic        ALUSrcE;
   logic [2:0]  ALUControlE;
   logic        BranchTakenE;
   logic        MemWriteM;
   logic        RegWriteM;
   logic        MemtoRegE;
   logic        RegWriteW;
   logic        MemtoRegW;
   logic        PCSrcW;
   logic        PCWrPendingF;
`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0] BranchCnt;
   logic [PERF_W-1:0] CondFailCnt;
`endif
   if (PERF_W < 1) begin : g_chk
      $error("PERF_W must be at least 1");
   end
   modport master (
      input  InstrD, ALUFlags, FlushE,
      output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemWriteM, RegWriteM,
             MemtoRegE, RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF
`ifdef PIPE_CTRL_PERF_EN
      , output BranchCnt, CondFailCnt
`endif
   );
   modport slave (
      output InstrD, ALUFlags, FlushE,
      input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemWriteM, RegWriteM,
             MemtoRegE, RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF
`ifdef PIPE_CTRL_PERF_EN
      , input BranchCnt, CondFailCnt
`endif
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined control unit for a 5-stage ARM core
//   clk, reset : single clock, synchronous active-high reset
//   bus        : pipe_ctrl_if.master (InstrD/ALUFlags/FlushE in, stage controls out)
//   Optional PIPE_CTRL_PERF_EN adds saturating BranchCnt/CondFailCnt counters of PERF_W bits
module pipe_ctrl #(parameter int PERF_W = 32) (
   input logic         clk,
   input logic         reset,
   pipe_ctrl_if.master bus
);
   logic [3:0] w_cond, w_rd, w_cmd;
   logic [1:0] w_op, w_immsrc, w_regsrc, w_flagw;
   logic [5:0] w_funct;
   logic [2:0] w_aluctl, w_base;
   logic       w_regw, w_memw, w_m2r, w_br, w_alusrc, w_dp;
   logic       w_add, w_sub, w_and, w_orr, w_regwd, w_pcsd, w_condex, w_unused;
   logic       r_regw_e, r_memw_e, r_m2r_e, r_br_e, r_pcs_e, r_alusrc_e;
   logic [2:0] r_aluctl_e;
   logic [1:0] r_flagw_e;
   logic [3:0] r_cond_e, r_flags;
   logic       r_regw_m, r_memw_m, r_m2r_m, r_pcs_m, r_regw_w, r_m2r_w, r_pcs_w;
   assign {w_cond, w_op, w_funct} = bus.InstrD[19:8];
   assign w_rd     = bus.InstrD[3:0];
   assign w_unused = ^{w_cond, bus.InstrD[7:4]};
   always_comb begin
      w_regw   = 1'b0;
      w_memw   = 1'b0;
      w_m2r    = 1'b0;
      w_br     = 1'b0;
      w_alusrc = 1'b0;
      w_dp     = 1'b0;
      w_immsrc = 2'b00;
      w_regsrc = 2'b00;
      case (w_op)
         2'b00: begin
            w_regw   = 1'b1;
            w_alusrc = w_funct[5];
            w_dp     = 1'b1;
         end
         2'b01: begin
            w_regw   = w_funct[0];
            w_m2r    = w_funct[0];
            w_memw   = ~w_funct[0];
            w_alusrc = 1'b1;
            w_immsrc = 2'b01;
            w_regsrc = {~w_funct[0], 1'b0};
         end
         2'b10: begin
            w_br     = 1'b1;
            w_alusrc = 1'b1;
            w_immsrc = 2'b10;
            w_regsrc = 2'b01;
         end
         default: ;
      endcase
   end
   assign w_cmd = w_funct[4:1];
   assign w_add = w_cmd == 4'b0100;
   assign w_sub = w_cmd == 4'b0010;
   assign w_and = w_cmd == 4'b0000;
   assign w_orr = w_cmd == 4'b1100;
   // memory and branch instructions always use ADD; unsupported DP commands fall back to 000 as a NOP
   assign w_aluctl = !w_dp ? 3'b000 : w_sub ? 3'b001 : w_and ? 3'b010 : w_orr ? 3'b011 : 3'b000;
   assign w_regwd  = w_regw & (~w_dp | w_add | w_sub | w_and | w_orr);
   assign w_flagw  = (w_dp & (w_add | w_sub | w_and | w_orr)) ? {w_funct[0], w_funct[0] & (w_add | w_sub)} : 2'b00;
   assign w_pcsd   = w_regwd & (w_rd == 4'hF);
   always_ff @(posedge clk)
      {r_regw_e, r_memw_e, r_m2r_e, r_br_e, r_pcs_e, r_alusrc_e, r_aluctl_e, r_flagw_e, r_cond_e} <=
         (reset || bus.FlushE) ? '0 : {w_regwd, w_memw, w_m2r, w_br, w_pcsd, w_alusrc, w_aluctl, w_flagw, w_cond};
   // condition pairs share a base test; odd codes invert it, which also makes 1111 never execute
   assign w_base = r_cond_e[3:1];
   always_comb
      w_condex = r_cond_e[0] ^ (w_base == 3'd0 ? r_flags[2] :
                                w_base == 3'd1 ? r_flags[1] :
                                w_base == 3'd2 ? r_flags[3] :
                                w_base == 3'd3 ? r_flags[0] :
                                w_base == 3'd4 ? r_flags[1] & ~r_flags[2] :
                                w_base == 3'd5 ? r_flags[3] == r_flags[0] :
                                w_base == 3'd6 ? ~r_flags[2] & (r_flags[3] == r_flags[0]) : 1'b1);
   always_ff @(posedge clk)
      if (reset) r_flags <= 4'b0000;
      else if (w_condex) begin
         if (r_flagw_e[1]) r_flags[3:2] <= bus.ALUFlags[3:2];
         if (r_flagw_e[0]) r_flags[1:0] <= bus.ALUFlags[1:0];
      end
   always_ff @(posedge clk) begin
      {r_regw_m, r_memw_m, r_m2r_m, r_pcs_m} <=
         reset ? '0 : {r_regw_e & w_condex, r_memw_e & w_condex, r_m2r_e, r_pcs_e & w_condex};
      {r_regw_w, r_m2r_w, r_pcs_w} <= reset ? '0 : {r_regw_m, r_m2r_m, r_pcs_m};
   end
   assign bus.RegSrcD      = w_regsrc;
   assign bus.ImmSrcD      = w_immsrc;
   assign bus.ALUSrcE      = r_alusrc_e;
   assign bus.ALUControlE  = r_aluctl_e;
   assign bus.BranchTakenE = r_br_e & w_condex;
   assign bus.MemWriteM    = r_memw_m;
   assign bus.RegWriteM    = r_regw_m;
   assign bus.MemtoRegE    = r_m2r_e;
   assign bus.RegWriteW    = r_regw_w;
   assign bus.MemtoRegW    = r_m2r_w;
   assign bus.PCSrcW       = r_pcs_w;
   assign bus.PCWrPendingF = w_pcsd | r_pcs_e | r_pcs_m;
`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0] r_br_cnt, r_cf_cnt;
   logic              w_cf;
   assign w_cf = ~w_condex & (r_regw_e | r_memw_e | r_br_e | (|r_flagw_e));
   always_ff @(posedge clk) begin
      r_br_cnt <= reset ? '0 : r_br_cnt + PERF_W'(bus.BranchTakenE & ~&r_br_cnt);
      r_cf_cnt <= reset ? '0 : r_cf_cnt + PERF_W'(w_cf & ~&r_cf_cnt);
   end
   assign bus.BranchCnt   = r_br_cnt;
   assign bus.CondFailCnt = r_cf_cnt;
`else
   if (PERF_W < 1) begin : g_chk
      $error("PERF_W must be at least 1");
   end
`endif
endmodule
